// File: rtl/ovl_fire_pkg.sv
// Shared types for the OVL fire collector: record layout, record kind, FSM.
// Record fields are sized for the widest supported configuration.
package ovl_fire_pkg;

    localparam int REC_ID_W = 8;
    localparam int REC_TS_W = 64;

    typedef enum logic {
        REC_FAIL = 1'b0,
        REC_XCHK = 1'b1
    } rec_type_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } state_e;

    typedef struct packed {
        logic [REC_ID_W-1:0] chk_id;
        rec_type_e           kind;
        logic                multi;
        logic [REC_TS_W-1:0] stamp;
    } rec_t;

endpackage

// File: rtl/ovl_fire_fifo.sv
// Record FIFO for the fire collector: synchronous, full/empty flags,
// push into a full FIFO is accepted only when a pop happens in the same cycle.
import ovl_fire_pkg::*;

module ovl_fire_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  rec_t data_in,
    output rec_t data_out,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    rec_t           mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    assign data_out = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects OVL checker fire pulses into timestamped records and event counters.
// Cover counting is built only when OVL_FIRE_COVER_EN is defined.
import ovl_fire_pkg::*;

module ovl_fire_collector #(
    parameter int NUM_CHK     = 4,
    parameter int CNT_W       = 16,
    parameter int TS_W        = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int STOP_ON_OVF = 0,
    localparam int ID_W       = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_CHK*3-1:0] fire_in,
    input  logic               clear,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [ID_W-1:0]    rec_chk_id,
    output logic               rec_type,
    output logic               rec_multi,
    output logic [TS_W-1:0]    rec_time,
    output logic [CNT_W-1:0]   fail_count,
    output logic [CNT_W-1:0]   xchk_count,
    output logic [CNT_W-1:0]   cover_count,
    output logic               any_fail,
    output logic               overflow
);

    state_e             state;
    state_e             state_nx;
    logic [TS_W-1:0]    ts;
    logic [NUM_CHK-1:0] fail_v;
    logic [NUM_CHK-1:0] xchk_v;
    logic [NUM_CHK-1:0] cov_v;
    logic [ID_W-1:0]    sel_id;
    rec_type_e          sel_kind;
    logic               any_hit;
    logic               multi;
    logic               capture;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    rec_t               rec_in;
    rec_t               rec_out;

    for (genvar i = 0; i < NUM_CHK; i++) begin : g_split
        assign fail_v[i] = fire_in[3*i];
        assign xchk_v[i] = fire_in[3*i+1];
        assign cov_v[i]  = fire_in[3*i+2];
    end

    // Lowest index wins; within a checker a 2-state fail beats an X-check.
    always_comb begin
        sel_id   = '0;
        sel_kind = REC_FAIL;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (fail_v[i] || xchk_v[i]) begin
                sel_id   = ID_W'(i);
                sel_kind = fail_v[i] ? REC_FAIL : REC_XCHK;
            end
        end
    end

    assign any_hit = |{fail_v, xchk_v};
    assign multi   = $countones({fail_v, xchk_v}) > 1;

    assign capture = (state == S_RUN) && enable && !clear;
    assign push    = capture && any_hit;
    assign pop     = rec_valid && rec_ready && !clear;
    assign drop    = push && full && !pop;

    always_comb begin
        rec_in        = '0;
        rec_in.chk_id = REC_ID_W'(sel_id);
        rec_in.kind   = sel_kind;
        rec_in.multi  = multi;
        rec_in.stamp  = REC_TS_W'(ts);
    end

    ovl_fire_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .push     (push),
        .pop      (pop),
        .data_in  (rec_in),
        .data_out (rec_out),
        .full     (full),
        .empty    (empty)
    );

    assign rec_valid  = !empty;
    assign rec_chk_id = ID_W'(rec_out.chk_id);
    assign rec_type   = rec_out.kind;
    assign rec_multi  = rec_out.multi;
    assign rec_time   = TS_W'(rec_out.stamp);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (enable) state_nx = S_RUN;
            end
            S_RUN: begin
                if (STOP_ON_OVF != 0 && drop) state_nx = S_FROZEN;
                else if (!enable)             state_nx = S_IDLE;
            end
            S_FROZEN: state_nx = S_FROZEN;
            default:  state_nx = S_IDLE;
        endcase
        if (clear) state_nx = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fail_count <= '0;
            xchk_count <= '0;
            any_fail   <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            fail_count <= '0;
            xchk_count <= '0;
            any_fail   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (capture && |fail_v) begin
                any_fail <= 1'b1;
                if (fail_count != '1) fail_count <= fail_count + 1'b1;
            end
            if (capture && |xchk_v && xchk_count != '1)
                xchk_count <= xchk_count + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef OVL_FIRE_COVER_EN
    logic [CNT_W-1:0] cover_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      cover_q <= '0;
        else if (clear)  cover_q <= '0;
        else if (capture && |cov_v && cover_q != '1)
            cover_q <= cover_q + 1'b1;
    end

    assign cover_count = cover_q;
`else
    logic cov_unused;

    assign cov_unused  = |cov_v;
    assign cover_count = '0;
`endif

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Randomized scoreboard bench for ovl_fire_collector with a queue-based model;
// a negedge monitor pops expected records whenever the DUT hands one over.
module tb_ovl_fire_collector;

    localparam int N     = 4;
    localparam int CW    = 16;
    localparam int TW    = 32;
    localparam int DEPTH = 8;

    typedef struct {
        int id;
        bit typ;
        bit multi;
        int t;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          rec_ready = 1'b0;
    logic [3*N-1:0] fire_in = '0;

    logic          rec_valid;
    logic [1:0]    rec_chk_id;
    logic          rec_type;
    logic          rec_multi;
    logic [TW-1:0] rec_time;
    logic [CW-1:0] fail_count;
    logic [CW-1:0] xchk_count;
    logic [CW-1:0] cover_count;
    logic          any_fail;
    logic          overflow;

    logic          s_valid;
    logic [1:0]    s_chk_id;
    logic          s_type;
    logic          s_multi;
    logic [TW-1:0] s_time;
    logic [CW-1:0] s_fail;
    logic [CW-1:0] s_xchk;
    logic [CW-1:0] s_cover;
    logic          s_any;
    logic          s_ovf;

    int   checks = 0;
    int   passed = 0;
    int   pops = 0;
    int   cyc = 0;
    exp_t q[$];

    int   m_fail, m_xchk, m_cov;
    bit   m_any, m_ovf, m_run;

    always #5 clock = ~clock;

    ovl_fire_collector #(
        .NUM_CHK(N), .CNT_W(CW), .TS_W(TW),
        .FIFO_DEPTH(DEPTH), .STOP_ON_OVF(0)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .fire_in(fire_in), .clear(clear),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_chk_id(rec_chk_id), .rec_type(rec_type),
        .rec_multi(rec_multi), .rec_time(rec_time),
        .fail_count(fail_count), .xchk_count(xchk_count),
        .cover_count(cover_count), .any_fail(any_fail),
        .overflow(overflow)
    );

    ovl_fire_collector #(
        .NUM_CHK(N), .CNT_W(CW), .TS_W(TW),
        .FIFO_DEPTH(DEPTH), .STOP_ON_OVF(1)
    ) dut_s (
        .clock(clock), .reset(reset), .enable(enable),
        .fire_in(fire_in), .clear(clear),
        .rec_valid(s_valid), .rec_ready(rec_ready),
        .rec_chk_id(s_chk_id), .rec_type(s_type),
        .rec_multi(s_multi), .rec_time(s_time),
        .fail_count(s_fail), .xchk_count(s_xchk),
        .cover_count(s_cover), .any_fail(s_any),
        .overflow(s_ovf)
    );

    // Cycles since reset release; equals the DUT timestamp between edges.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int sat(input int v);
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
    endfunction

    // Monitor: pop and compare on every accepted handshake.
    bit            held = 0;
    logic [1:0]    h_id;
    logic [TW-1:0] h_time;
    always @(negedge clock) begin
        exp_t e;
        if (!reset || clear || !rec_valid) begin
            held = 0;
        end else begin
            if (held) begin
                chk("hold_id", rec_chk_id, h_id);
                chk("hold_time", rec_time, h_time);
            end
            if (rec_ready) begin
                held = 0;
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rec: id %0d time %0d, none expected",
                             rec_chk_id, rec_time);
                end else begin
                    e = q.pop_front();
                    chk("rec_chk_id", rec_chk_id, e.id);
                    chk("rec_type", rec_type, e.typ);
                    chk("rec_multi", rec_multi, e.multi);
                    chk("rec_time", rec_time, e.t);
                    pops++;
                end
            end else begin
                held = 1;
                h_id = rec_chk_id;
                h_time = rec_time;
            end
        end
    end

    // Drive one cycle, update the model for the coming edge, check after it.
    task automatic step(input logic en, input logic [3*N-1:0] f,
                        input logic rdy, input logic clr);
        int first, nb;
        bit ftyp, anyf, anyx, anyc, cap, popn;
        exp_t e;
        enable = en;
        fire_in = f;
        rec_ready = rdy;
        clear = clr;
        first = -1; nb = 0; ftyp = 0;
        anyf = 0; anyx = 0; anyc = 0;
        for (int i = 0; i < N; i++) begin
            if (f[3*i])   begin nb++; anyf = 1; end
            if (f[3*i+1]) begin nb++; anyx = 1; end
            if (f[3*i+2]) anyc = 1;
            if (first < 0 && (f[3*i] || f[3*i+1])) begin
                first = i;
                ftyp = !f[3*i];
            end
        end
        cap = m_run && en && !clr;
        popn = (q.size() > 0) && rdy && !clr;
        if (clr) begin
            q.delete();
            m_fail = 0; m_xchk = 0; m_cov = 0;
            m_any = 0; m_ovf = 0; m_run = 0;
        end else begin
            if (cap && first >= 0) begin
                if (q.size() == DEPTH && !popn) begin
                    m_ovf = 1;
                end else begin
                    e.id = first; e.typ = ftyp;
                    e.multi = (nb > 1); e.t = cyc;
                    q.push_back(e);
                end
            end
            if (cap && anyf) begin m_fail = sat(m_fail + 1); m_any = 1; end
            if (cap && anyx) m_xchk = sat(m_xchk + 1);
`ifdef OVL_FIRE_COVER_EN
            if (cap && anyc) m_cov = sat(m_cov + 1);
`endif
            m_run = en;
        end
        @(posedge clock);
        #1;
        chk("fail_count", fail_count, m_fail);
        chk("xchk_count", xchk_count, m_xchk);
        chk("cover_count", cover_count, m_cov);
        chk("any_fail", any_fail, m_any);
        chk("overflow", overflow, m_ovf);
        chk("rec_valid", rec_valid, q.size() > 0);
    endtask

    task automatic do_clear(input logic rdy);
        step(1, '0, rdy, 1);
        step(1, '0, rdy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, rec_valid, 0);
        chk({tag, "_fail"}, fail_count, 0);
        chk({tag, "_xchk"}, xchk_count, 0);
        chk({tag, "_cover"}, cover_count, 0);
        chk({tag, "_any"}, any_fail, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    function automatic logic [3*N-1:0] one_fail(input int i);
        logic [3*N-1:0] v;
        v = '0;
        v[3*i] = 1'b1;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        logic [31:0] r;
        logic [3*N-1:0] f;
        m_fail = 0; m_xchk = 0; m_cov = 0;
        m_any = 0; m_ovf = 0; m_run = 0;

        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1;

        // checker 2 fails at timestamp 10
        repeat (10) step(1, '0, 1, 0);
        step(1, one_fail(2), 1, 0);
        chk("t1_valid", rec_valid, 1);
        chk("t1_id", rec_chk_id, 2);
        chk("t1_type", rec_type, 0);
        chk("t1_multi", rec_multi, 0);
        chk("t1_time", rec_time, 10);
        chk("t1_fail", fail_count, 1);
        chk("t1_any", any_fail, 1);

        // checker 1 X-check and checker 3 fail together
        do_clear(1);
        f = '0; f[4] = 1'b1; f[9] = 1'b1;
        step(1, f, 1, 0);
        chk("t2_id", rec_chk_id, 1);
        chk("t2_type", rec_type, 1);
        chk("t2_multi", rec_multi, 1);
        chk("t2_fail", fail_count, 1);
        chk("t2_xchk", xchk_count, 1);

        // overflow with ready held low
        do_clear(1);
        rec_ready = 0;
        for (int i = 0; i < 9; i++)
            step(1, one_fail($urandom_range(0, N - 1)), 0, 0);
        chk("t3_ovf", overflow, 1);
        chk("t3_fail", fail_count, 9);
        chk("t3_s_ovf", s_ovf, 1);
        chk("t3_s_fail", s_fail, 9);
        chk("t3_s_valid", s_valid, 1);
        step(1, one_fail(0), 0, 0);
        chk("t3_s_frozen", s_fail, 9);
        base = pops;
        repeat (DEPTH + 2) step(1, '0, 1, 0);
        chk("t3_drained", pops - base, DEPTH);

        // full FIFO with pop and push in the same cycle
        do_clear(0);
        for (int i = 0; i < DEPTH; i++) step(1, one_fail(i % N), 0, 0);
        step(1, one_fail(3), 1, 0);
        chk("t4_ovf", overflow, 0);
        base = pops;
        repeat (DEPTH + 2) step(1, '0, 1, 0);
        chk("t4_occupancy", pops - base, DEPTH);

        // disabled capture, then clear with records queued
        do_clear(1);
        repeat (4) step(0, one_fail(1) | 12'h0A2, 0, 0);
        chk("t5_fail", fail_count, 0);
        chk("t5_valid", rec_valid, 0);
        step(1, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, one_fail(i), 0, 0);
        chk("t5_queued", rec_valid, 1);
        step(1, one_fail(0), 1, 1);
        chk("t5_clr_valid", rec_valid, 0);
        chk("t5_clr_fail", fail_count, 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            f = ($urandom_range(0, 3) == 0) ? '0 : r[3*N-1:0];
            step($urandom_range(0, 9) != 0, f, $urandom_range(0, 1),
                 $urandom_range(0, 59) == 0);
        end
        repeat (DEPTH + 2) step(1, '0, 1, 0);

        // reset in the middle of a burst
        step(1, '0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, one_fail(i % N), 0, 0);
        #2 reset = 0;
        q.delete();
        m_fail = 0; m_xchk = 0; m_cov = 0;
        m_any = 0; m_ovf = 0; m_run = 0;
        #1;
        check_zero("midrst");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1;
        step(1, '0, 0, 0);
        step(1, one_fail(0), 0, 0);
        chk("t6_valid", rec_valid, 1);
        chk("t6_time", rec_time, 1);
        repeat (4) step(1, '0, 1, 0);
        chk("sb_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
